// File: rtl/frame_ecc_scrub_ctrl.sv
// Configuration-memory readback scrub sequencer: walks every frame, classifies the
// FRAME_ECC result, hands bad frames to the host as log records and counts them.
module frame_ecc_scrub_ctrl #(
   parameter int NUM_FRAMES = 1024,
   parameter int FRAME_AW   = 10,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                frame_req_o,
   output logic [FRAME_AW-1:0] frame_addr_o,
   input  logic                frame_ack_i,
   input  logic                ecc_syndromevalid_i,
   input  logic                ecc_error_i,
   input  logic [11:0]         ecc_syndrome_i,
   output logic                log_valid_o,
   input  logic                log_ack_i,
   output logic [FRAME_AW-1:0] log_addr_o,
   output logic [11:0]         log_syndrome_o,
   output logic [1:0]          log_type_o,
   output logic [CNT_W-1:0]    sbe_cnt_o,
   output logic [CNT_W-1:0]    dbe_cnt_o,
   output logic [CNT_W-1:0]    to_cnt_o
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_LOG  = 3'd3;
   localparam logic [2:0] S_NEXT = 3'd4;

   localparam logic [1:0] T_SBE = 2'b01;
   localparam logic [1:0] T_DBE = 2'b10;
   localparam logic [1:0] T_TO  = 2'b11;

   logic [2:0]          state_q, state_d;
   logic [FRAME_AW-1:0] addr_q, addr_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    sbe_q, sbe_d, dbe_q, dbe_d, to_q, to_d;
   logic [FRAME_AW-1:0] laddr_q, laddr_d;
   logic [11:0]         lsyn_q, lsyn_d;
   logic [1:0]          ltype_q, ltype_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tmr_d   = tmr_q;
      done_d  = 1'b0;
      sbe_d   = sbe_q;
      dbe_d   = dbe_q;
      to_d    = to_q;
      laddr_d = laddr_q;
      lsyn_d  = lsyn_q;
      ltype_d = ltype_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               state_d = S_REQ;
               addr_d  = '0;
               sbe_d   = '0;
               dbe_d   = '0;
               to_d    = '0;
            end
            S_REQ: if (frame_ack_i) begin
               state_d = S_WAIT;
               tmr_d   = '0;
            end
            S_WAIT: begin
               // A syndrome arriving in the expiry cycle takes precedence over the timeout.
               if (ecc_syndromevalid_i) begin
                  if (!ecc_error_i) begin
                     state_d = S_NEXT;
                  end else begin
                     state_d = S_LOG;
                     laddr_d = addr_q;
                     lsyn_d  = ecc_syndrome_i;
                     if (ecc_syndrome_i[11]) begin
                        ltype_d = T_SBE;
                        sbe_d   = sat_inc(sbe_q);
                     end else begin
                        ltype_d = T_DBE;
                        dbe_d   = sat_inc(dbe_q);
                     end
                  end
               end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                  state_d = S_LOG;
                  laddr_d = addr_q;
                  lsyn_d  = '0;
                  ltype_d = T_TO;
                  to_d    = sat_inc(to_q);
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            S_LOG: if (log_ack_i) state_d = S_NEXT;
            S_NEXT: begin
               if (addr_q == FRAME_AW'(NUM_FRAMES - 1)) begin
                  state_d = S_IDLE;
                  addr_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
                  addr_d  = addr_q + FRAME_AW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         tmr_q   <= '0;
         done_q  <= 1'b0;
         sbe_q   <= '0;
         dbe_q   <= '0;
         to_q    <= '0;
         laddr_q <= '0;
         lsyn_q  <= '0;
         ltype_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tmr_q   <= tmr_d;
         done_q  <= done_d;
         sbe_q   <= sbe_d;
         dbe_q   <= dbe_d;
         to_q    <= to_d;
         laddr_q <= laddr_d;
         lsyn_q  <= lsyn_d;
         ltype_q <= ltype_d;
      end
   end

   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = done_q;
   assign frame_req_o    = (state_q == S_REQ);
   assign frame_addr_o   = addr_q;
   assign log_valid_o    = (state_q == S_LOG);
   assign log_addr_o     = laddr_q;
   assign log_syndrome_o = lsyn_q;
   assign log_type_o     = ltype_q;
   assign sbe_cnt_o      = sbe_q;
   assign dbe_cnt_o      = dbe_q;
   assign to_cnt_o       = to_q;

endmodule

// File: tb/tb_frame_ecc_scrub_ctrl.sv
// Bench for frame_ecc_scrub_ctrl: table-driven and random scans against a per-frame
// classification model, plus abort/start-while-busy and async reset sequences.
module tb_frame_ecc_scrub_ctrl;
   localparam int NF = 5;
   localparam int AW = 3;
   localparam int TO = 8;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, frame_ack, ecc_v, ecc_err, log_ack;
   logic [11:0]   ecc_syn;
   logic          busy, done, frame_req, log_valid;
   logic [AW-1:0] frame_addr, log_addr;
   logic [11:0]   log_syn;
   logic [1:0]    log_type;
   logic [CW-1:0] sbe, dbe, toc;

   int checks = 0;
   int errors = 0;
   int m_sbe, m_dbe, m_to;

   always #5 clk = ~clk;

   frame_ecc_scrub_ctrl #(.NUM_FRAMES(NF), .FRAME_AW(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .busy_o(busy),
      .done_o(done), .frame_req_o(frame_req), .frame_addr_o(frame_addr),
      .frame_ack_i(frame_ack), .ecc_syndromevalid_i(ecc_v), .ecc_error_i(ecc_err),
      .ecc_syndrome_i(ecc_syn), .log_valid_o(log_valid), .log_ack_i(log_ack),
      .log_addr_o(log_addr), .log_syndrome_o(log_syn), .log_type_o(log_type),
      .sbe_cnt_o(sbe), .dbe_cnt_o(dbe), .to_cnt_o(toc)
   );

   // dly: WAIT_SYN cycles before the syndrome shows up; 4'hF means it never does
   typedef struct {
      logic [NF-1:0][3:0]  dly;
      logic [NF-1:0]       err;
      logic [NF-1:0][11:0] syn;
      int                  hold;
      int                  e_sbe, e_dbe, e_to;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference classification: 0 clean, 1 single-bit, 2 double-bit, 3 timeout
   function automatic int exp_type(input int dly, input bit err, input logic [11:0] syn);
      if (dly < 0) return 3;
      if (!err) return 0;
      return syn[11] ? 1 : 2;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic start_scan();
      start = 1'b1;
      step();
      start = 1'b0;
      m_sbe = 0; m_dbe = 0; m_to = 0;
      chk("start_busy", busy, 1);
      chk("start_req", frame_req, 1);
   endtask

   task automatic wait_req();
      int t = 0;
      while (frame_req !== 1'b1 && t < 50) begin step(); t++; end
      chk("req_seen", frame_req, 1);
   endtask

   // Serves one frame as readback engine + ECC + host; ends in NEXT, then steps once.
   task automatic do_frame(input int idx, input int dly, input bit err, input logic [11:0] syn,
                           input int hold, input int acklat, input bit last);
      int ty;
      wait_req();
      chk("req_addr", frame_addr, idx);
      for (int k = 0; k < acklat; k++) begin
         log_ack = 1'($urandom % 2); ecc_v = 1'b1; ecc_err = 1'b1; ecc_syn = 12'hFFF;
         step();
         chk("req_hold", frame_req, 1);
      end
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0; log_ack = 1'b0; ecc_v = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         chk("wait_no_req", frame_req, 0);
         chk("wait_no_log", log_valid, 0);
         frame_ack = (k == 2);
         if (dly == k - 1) begin
            ecc_v = 1'b1; ecc_err = err; ecc_syn = syn;
            step();
            ecc_v = 1'b0;
            break;
         end
         step();
      end
      frame_ack = 1'b0;
      ty = exp_type(dly, err, syn);
      if (ty == 1) m_sbe++;
      if (ty == 2) m_dbe++;
      if (ty == 3) m_to++;
      if (ty != 0) begin
         chk("log_valid", log_valid, 1);
         chk("log_addr", log_addr, idx);
         chk("log_type", log_type, ty);
         chk("log_syn", log_syn, (ty == 3) ? 12'h0 : syn);
         for (int k = 0; k < hold; k++) begin
            ecc_v = 1'b1; ecc_err = 1'b1; ecc_syn = 12'hFFF; frame_ack = 1'b1;
            step();
            chk("log_stall_req", frame_req, 0);
            chk("log_held", log_valid, 1);
            chk("log_type_stable", log_type, ty);
         end
         ecc_v = 1'b0; frame_ack = 1'b0; log_ack = 1'b1;
         step();
         log_ack = 1'b0;
      end
      chk("next_no_log", log_valid, 0);
      chk("next_no_req", frame_req, 0);
      chk("next_no_done", done, 0);
      step();
      if (last) begin
         chk("done_pulse", done, 1);
         chk("done_idle", busy, 0);
         step();
         chk("done_1cyc", done, 0);
      end else begin
         chk("next_req", frame_req, 1);
      end
   endtask

   initial begin
      vec_t v;
      int d;
      rst = 1'b1;
      {start, abort, frame_ack, ecc_v, ecc_err, log_ack} = '0;
      ecc_syn = '0;

      vecs[0] = '{dly: {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, err: 5'b00000, syn: '0,
                  hold: 0, e_sbe: 0, e_dbe: 0, e_to: 0};
      vecs[1] = '{dly: {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, err: 5'b00100,
                  syn: {12'h0, 12'h0, 12'h8A5, 12'h0, 12'h0},
                  hold: 10, e_sbe: 1, e_dbe: 0, e_to: 0};
      vecs[2] = '{dly: {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, err: 5'b00010,
                  syn: {12'h0, 12'h0, 12'h0, 12'h0A5, 12'h0},
                  hold: 2, e_sbe: 0, e_dbe: 1, e_to: 0};
      vecs[3] = '{dly: {4'd1, 4'd1, 4'd1, 4'd7, 4'hF}, err: 5'b00010,
                  syn: {12'h0, 12'h0, 12'h0, 12'h800, 12'h0},
                  hold: 1, e_sbe: 1, e_dbe: 0, e_to: 1};
      vecs[4] = '{dly: {4'd0, 4'd3, 4'd7, 4'd2, 4'd0}, err: 5'b11111,
                  syn: {12'h801, 12'hFFF, 12'h800, 12'hA00, 12'h8A5},
                  hold: 0, e_sbe: 3, e_dbe: 0, e_to: 0};
      vecs[5] = '{dly: {4'd2, 4'hF, 4'd0, 4'hF, 4'd4}, err: 5'b00101,
                  syn: {12'h0, 12'h0, 12'h811, 12'h0, 12'h0A5},
                  hold: 3, e_sbe: 1, e_dbe: 1, e_to: 2};

      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", frame_req, 0);
      chk("rst_addr", frame_addr, 0);
      chk("rst_log_valid", log_valid, 0);
      chk("rst_log_fields", {log_addr, log_syn, log_type}, 0);
      chk("rst_cnts", {sbe, dbe, toc}, 0);
      step();
      rst = 1'b0;
      step();

      // table-driven scans
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         start_scan();
         for (int f = 0; f < NF; f++) begin
            d = (v.dly[f] == 4'hF) ? -1 : int'(v.dly[f]);
            do_frame(f, d, v.err[f], v.syn[f], v.hold, i % 3, f == NF - 1);
         end
         chk("tbl_sbe", sbe, v.e_sbe);
         chk("tbl_dbe", dbe, v.e_dbe);
         chk("tbl_to", toc, v.e_to);
      end

      // random scans against the model
      for (int s = 0; s < 8; s++) begin
         start_scan();
         for (int f = 0; f < NF; f++) begin
            d = ($urandom % 3 == 0) ? -1 : int'($urandom % TO);
            do_frame(f, d, 1'($urandom % 2), 12'($urandom), int'($urandom % 4),
                     int'($urandom % 4), f == NF - 1);
         end
         chk("rnd_sbe", sbe, sat(m_sbe));
         chk("rnd_dbe", dbe, sat(m_dbe));
         chk("rnd_to", toc, sat(m_to));
      end

      // abort while requesting frame 3
      start_scan();
      do_frame(0, 1, 1'b0, 12'h0, 0, 0, 1'b0);
      do_frame(1, 0, 1'b1, 12'h9C3, 1, 0, 1'b0);
      do_frame(2, 1, 1'b0, 12'h0, 0, 0, 1'b0);
      chk("abort_at_addr", frame_addr, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_req", frame_req, 0);
      chk("abort_no_done", done, 0);
      chk("abort_keeps_sbe", sbe, 1);
      step();
      chk("abort_no_done_late", done, 0);

      // START while busy, then START+ABORT both mid-scan and in IDLE
      start_scan();
      do_frame(0, 2, 1'b1, 12'h812, 0, 1, 1'b0);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      chk("busy_start_addr", frame_addr, 1);
      chk("busy_start_req", frame_req, 1);
      chk("busy_start_cnt", sbe, 1);
      start = 1'b1; abort = 1'b1;
      step();
      chk("abort_start_busy", busy, 0);
      step();
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_start", busy, 0);
      chk("idle_abort_cnt", sbe, 1);
      step();
      chk("idle_abort_stay", busy, 0);

      // async reset while a record is pending
      start_scan();
      do_frame(0, 1, 1'b0, 12'h0, 0, 0, 1'b0);
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0; ecc_v = 1'b1; ecc_err = 1'b1; ecc_syn = 12'h8A5;
      step();
      ecc_v = 1'b0;
      chk("pre_rst_log", log_valid, 1);
      chk("pre_rst_addr", log_addr, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_log_valid", log_valid, 0);
      chk("arst_log_fields", {log_addr, log_syn, log_type}, 0);
      chk("arst_cnts", {sbe, dbe, toc}, 0);
      chk("arst_addr", frame_addr, 0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
